// File: rtl/btb_pkg.sv
// Shared types for the BTB update queue: the queued update record and the
// drain-FSM state encoding.
package btb_pkg;

  localparam int BTB_DEPTH      = 4;
  localparam int BTB_ADDR_WIDTH = 32;
  localparam int BTB_CNT_WIDTH  = 8;

  typedef struct packed {
    logic [BTB_ADDR_WIDTH-1:0] pc;
    logic [BTB_ADDR_WIDTH-1:0] target;
    logic                      taken;
  } btb_upd_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } btb_state_e;

endpackage

// File: rtl/btb_upd_fifo.sv
// Generic circular-buffer FIFO with synchronous reset; the head entry is
// presented combinationally and a push is never visible before the next cycle.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int  DEPTH   = BTB_DEPTH,
  parameter type entry_t = btb_upd_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  entry_t                   din,
  input  logic                     pop,
  output entry_t                   dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_CNT = DEPTH[PW:0];

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   cnt;

  // Storage needs no reset: contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign count = cnt;
  assign full  = (cnt == DEPTH_CNT);
  assign empty = (cnt == '0);

endmodule

// File: rtl/btb_update_queue.sv
// Buffers resolved-branch updates and drains them one at a time to the BTB
// write controller; updates arriving while full are dropped and counted.
module btb_update_queue
  import btb_pkg::*;
#(
  parameter int DEPTH      = BTB_DEPTH,
  parameter int ADDR_WIDTH = BTB_ADDR_WIDTH,
  parameter int CNT_WIDTH  = BTB_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     upd_valid,
  input  logic [ADDR_WIDTH-1:0]    upd_pc,
  input  logic [ADDR_WIDTH-1:0]    upd_target,
  input  logic                     upd_taken,
  output logic                     btb_write,
  output logic [ADDR_WIDTH-1:0]    btb_pc,
  output logic [ADDR_WIDTH-1:0]    btb_target,
  output logic                     btb_taken,
  input  logic                     btb_resp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_WIDTH-1:0]     drop_count
);

  // Same layout as btb_upd_t, but sized by this instance's ADDR_WIDTH.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] target;
    logic                  taken;
  } upd_t;

  btb_state_e           state;
  btb_state_e           state_nxt;
  upd_t                 din;
  upd_t                 head;
  logic                 push;
  logic                 pop;
  logic                 drop;
  logic [CNT_WIDTH-1:0] drop_cnt;

  assign din  = '{pc: upd_pc, target: upd_target, taken: upd_taken};
  assign pop  = (state == WAIT) && btb_resp;
  // A pop in the same cycle frees a slot, so a full queue still accepts.
  assign push = upd_valid && (!full || pop);
  assign drop = upd_valid && full && !pop;

  btb_upd_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (upd_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A resp seen in IDLE is spurious (e.g. straight after reset) and ignored.
  always_comb begin
    state_nxt = state;
    btb_write = 1'b0;
    case (state)
      IDLE: begin
        btb_write = !empty;
        if (!empty) begin
          state_nxt = WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        btb_write = !btb_resp;
        if (btb_resp) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT;
        end
      end
      default: begin
        state_nxt = IDLE;
        btb_write = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != {CNT_WIDTH{1'b1}})) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign btb_pc     = head.pc;
  assign btb_target = head.target;
  assign btb_taken  = head.taken;
  assign drop_count = drop_cnt;

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed bench for btb_update_queue; a second instance with a 2-bit drop
// counter exercises saturation on the same stimulus.
module tb_btb_update_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        btb_resp;
  logic        resp_en;

  logic        btb_write,  btb_write2;
  logic [31:0] btb_pc,     btb_pc2;
  logic [31:0] btb_target, btb_target2;
  logic        btb_taken,  btb_taken2;
  logic [2:0]  count,      count2;
  logic        full,       full2;
  logic        empty,      empty2;
  logic [7:0]  drop_count;
  logic [1:0]  drop_count2;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  btb_update_queue #(.DEPTH(4), .ADDR_WIDTH(32), .CNT_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken), .btb_write(btb_write),
    .btb_pc(btb_pc), .btb_target(btb_target), .btb_taken(btb_taken),
    .btb_resp(btb_resp), .count(count), .full(full), .empty(empty),
    .drop_count(drop_count)
  );

  btb_update_queue #(.DEPTH(4), .ADDR_WIDTH(32), .CNT_WIDTH(2)) u_dut_sat (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken), .btb_write(btb_write2),
    .btb_pc(btb_pc2), .btb_target(btb_target2), .btb_taken(btb_taken2),
    .btb_resp(btb_resp), .count(count2), .full(full2), .empty(empty2),
    .drop_count(drop_count2)
  );

  // One clock; the BTB model answers a write seen last cycle when enabled.
  task automatic tick();
    logic w;
    w = btb_write;
    @(posedge clk);
    #1;
    btb_resp = resp_en & w;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; upd_valid = 1'b0; resp_en = 1'b0; btb_resp = 1'b0;
    tick();
    rst = 1'b0; btb_resp = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; upd_valid = 1'b0; resp_en = 1'b0; btb_resp = 1'b0;
    upd_pc = 32'h0; upd_target = 32'h0; upd_taken = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tests++; if (count !== 3'd0) begin failed++; $display("FAIL reset_count: got %0d exp 0", count); end
    tests++; if (empty !== 1'b1 || full !== 1'b0) begin failed++; $display("FAIL reset_flags: empty=%0b full=%0b exp 1/0", empty, full); end
    tests++; if (drop_count !== 8'd0 || drop_count2 !== 2'd0) begin failed++; $display("FAIL reset_drop: got %0d/%0d exp 0", drop_count, drop_count2); end
    tests++; if (btb_write !== 1'b0) begin failed++; $display("FAIL reset_write: got %0b exp 0", btb_write); end
    btb_resp = 1'b1;
    tick();
    btb_resp = 1'b0;
    tests++; if (count !== 3'd0 || btb_write !== 1'b0) begin failed++; $display("FAIL reset_spurious_resp: count=%0d write=%0b exp 0/0", count, btb_write); end
  endtask

  task automatic test_single();
    do_reset();
    resp_en = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_target = 32'h200; upd_taken = 1'b1;
    tick();
    upd_valid = 1'b0;
    tests++; if (btb_write !== 1'b1) begin failed++; $display("FAIL single_write_c1: got %0b exp 1", btb_write); end
    tests++; if (btb_pc !== 32'h100 || btb_target !== 32'h200 || btb_taken !== 1'b1) begin
      failed++; $display("FAIL single_fields_c1: got %h/%h/%0b exp 100/200/1", btb_pc, btb_target, btb_taken); end
    tick();
    tests++; if (btb_write !== 1'b0 || count !== 3'd1) begin failed++; $display("FAIL single_c2: write=%0b count=%0d exp 0/1", btb_write, count); end
    tick();
    tests++; if (empty !== 1'b1 || btb_write !== 1'b0) begin failed++; $display("FAIL single_c3: empty=%0b write=%0b exp 1/0", empty, btb_write); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  cnt_exp [7] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0};
    logic        wr_exp  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] pc_exp;
    do_reset();
    resp_en = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c < 3) begin
        upd_valid = 1'b1; upd_pc = 32'h10 * 32'(c + 1); upd_target = 32'h1000 + upd_pc; upd_taken = c[0];
      end else begin
        upd_valid = 1'b0;
      end
      tick();
      tests++; if (count !== cnt_exp[c]) begin failed++; $display("FAIL burst_count_c%0d: got %0d exp %0d", c + 1, count, cnt_exp[c]); end
      tests++; if (btb_write !== wr_exp[c]) begin failed++; $display("FAIL burst_write_c%0d: got %0b exp %0b", c + 1, btb_write, wr_exp[c]); end
      if (wr_exp[c]) begin
        pc_exp = 32'h10 * 32'(c / 2 + 1);
        tests++; if (btb_pc !== pc_exp) begin failed++; $display("FAIL burst_pc_c%0d: got %h exp %h", c + 1, btb_pc, pc_exp); end
      end
    end
    tests++; if (empty !== 1'b1) begin failed++; $display("FAIL burst_empty_c7: got %0b exp 1", empty); end
  endtask

  task automatic test_overflow();
    int idx;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      upd_valid = 1'b1; upd_pc = 32'h40 + 32'(4 * i); upd_target = 32'h900 + 32'(i); upd_taken = 1'b0;
      tick();
      if (i == 3) begin
        tests++; if (full !== 1'b1 || count !== 3'd4) begin failed++; $display("FAIL ovf_full: full=%0b count=%0d exp 1/4", full, count); end
      end
    end
    upd_valid = 1'b0;
    tests++; if (drop_count !== 8'd2) begin failed++; $display("FAIL ovf_drop: got %0d exp 2", drop_count); end
    tests++; if (drop_count2 !== 2'd2) begin failed++; $display("FAIL ovf_drop_sat_inst: got %0d exp 2", drop_count2); end
    resp_en = 1'b1;
    idx = 0;
    for (int k = 0; k < 40 && idx < 4; k++) begin
      tick();
      if (btb_resp) begin
        tests++; if (btb_pc !== 32'h40 + 32'(4 * idx)) begin failed++; $display("FAIL ovf_order_%0d: got %h exp %h", idx, btb_pc, 32'h40 + 32'(4 * idx)); end
        idx++;
      end
    end
    tests++; if (idx != 4) begin failed++; $display("FAIL ovf_drain_timeout: drained %0d exp 4", idx); end
    tick();
    tests++; if (empty !== 1'b1) begin failed++; $display("FAIL ovf_empty: got %0b exp 1", empty); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] order [4] = '{32'h84, 32'h88, 32'h8C, 32'hAA0};
    int idx;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      upd_valid = 1'b1; upd_pc = 32'h80 + 32'(4 * i); upd_target = 32'h0; upd_taken = 1'b1;
      tick();
    end
    upd_valid = 1'b0;
    tests++; if (full !== 1'b1 || btb_write !== 1'b1) begin failed++; $display("FAIL fpp_full: full=%0b write=%0b exp 1/1", full, btb_write); end
    resp_en = 1'b1;
    tick();
    upd_valid = 1'b1; upd_pc = 32'hAA0; upd_target = 32'hBB0; upd_taken = 1'b0;
    tick();
    upd_valid = 1'b0;
    tests++; if (count !== 3'd4 || full !== 1'b1) begin failed++; $display("FAIL fpp_count: count=%0d full=%0b exp 4/1", count, full); end
    tests++; if (drop_count !== 8'd0) begin failed++; $display("FAIL fpp_drop: got %0d exp 0", drop_count); end
    idx = 0;
    for (int k = 0; k < 40 && idx < 4; k++) begin
      tick();
      if (btb_resp) begin
        tests++; if (btb_pc !== order[idx]) begin failed++; $display("FAIL fpp_order_%0d: got %h exp %h", idx, btb_pc, order[idx]); end
        idx++;
      end
    end
    tests++; if (idx != 4) begin failed++; $display("FAIL fpp_drain_timeout: drained %0d exp 4", idx); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      upd_valid = 1'b1; upd_pc = 32'h300 + 32'(4 * i); upd_target = 32'h0; upd_taken = 1'b0;
      tick();
    end
    upd_valid = 1'b0;
    tests++; if (btb_write !== 1'b1 || count !== 3'd2) begin failed++; $display("FAIL rmw_pre: write=%0b count=%0d exp 1/2", btb_write, count); end
    rst = 1'b1;
    tick();
    rst = 1'b0; btb_resp = 1'b1;
    #1;
    tests++; if (count !== 3'd0 || empty !== 1'b1 || btb_write !== 1'b0) begin
      failed++; $display("FAIL rmw_after_rst: count=%0d empty=%0b write=%0b exp 0/1/0", count, empty, btb_write); end
    tick();
    tests++; if (count !== 3'd0 || btb_write !== 1'b0) begin failed++; $display("FAIL rmw_spurious: count=%0d write=%0b exp 0/0", count, btb_write); end
    upd_valid = 1'b1; upd_pc = 32'h555; upd_target = 32'h666; upd_taken = 1'b1;
    tick();
    upd_valid = 1'b0;
    tests++; if (count !== 3'd1 || btb_pc !== 32'h555 || btb_write !== 1'b1) begin
      failed++; $display("FAIL rmw_repush: count=%0d pc=%h write=%0b exp 1/555/1", count, btb_pc, btb_write); end
  endtask

  task automatic test_drop_saturation();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      upd_valid = 1'b1; upd_pc = 32'hC00 + 32'(4 * i); upd_target = 32'h0; upd_taken = 1'b0;
      tick();
    end
    upd_valid = 1'b0;
    tests++; if (drop_count2 !== 2'd3) begin failed++; $display("FAIL sat_drop2: got %0d exp 3", drop_count2); end
    tests++; if (drop_count !== 8'd5) begin failed++; $display("FAIL sat_drop8: got %0d exp 5", drop_count); end
    tests++; if (count !== 3'd4) begin failed++; $display("FAIL sat_count: got %0d exp 4", count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_wait();
    test_drop_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
